fir_seq_ctrl: RTL

//  Sequencer for the 16-tap FIR datapath. Accepts samples on a valid/ready stream, issues one
//  fir_run per sample, holds fir_sample stable until fir_busy falls, captures filter_data into
//  a one-entry output register on a valid/ready stream. Owns double-buffered coefficients
//  (shadow written by host, active drives FIR); swap only between samples.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_coef_bank.sv | 53 +++++
 rtl/fir_seq_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared constants and the sequencer state type for the FIR control slice.
package fir_pkg;

    localparam int DATA_W  = 16;
    localparam int COEF_W  = 17;
    localparam int TAPS    = 16;
    localparam int TIMEOUT = 15;

    localparam int ADDR_W  = $clog2(TAPS);
    localparam int CNT_W   = $clog2(TIMEOUT + 1);

    localparam int unsigned TAPS_U = TAPS;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        HOLD
    } state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: the host writes the shadow bank, and a copy strobe
// moves the whole shadow bank into the active bank that drives the FIR.
module fir_coef_bank
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [COEF_W-1:0]        wr_data,
    input  logic                     copy_en,
    output logic [TAPS*COEF_W-1:0]   coeff_flat
);

    logic [COEF_W-1:0] shadow_q [TAPS];
    logic [COEF_W-1:0] shadow_d [TAPS];
    logic [COEF_W-1:0] active_q [TAPS];
    logic [COEF_W-1:0] active_d [TAPS];
    logic              wr_hit;

    // Next bank contents; the copy reads the already-updated shadow so a same-edge write is forwarded.
    always_comb begin
        wr_hit   = wr_en && (32'(wr_addr) < TAPS_U);
        shadow_d = shadow_q;
        active_d = active_q;
        if (wr_hit) begin
            shadow_d[wr_addr] = wr_data;
        end
        if (copy_en) begin
            active_d = shadow_d;
        end
    end

    // Bank registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // Flatten the active bank, coefficient k in slice k.
    always_comb begin
        coeff_flat = '0;
        for (int k = 0; k < TAPS; k++) begin
            coeff_flat[k*COEF_W +: COEF_W] = active_q[k];
        end
    end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer for the 16-tap FIR datapath: one fir_run per accepted sample, a one-entry
// result register with valid/ready, a busy-timeout guard, and coefficient bank swapping
// restricted to the gaps between samples.
module fir_seq_ctrl
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    input  logic                     coef_wr_en,
    input  logic [ADDR_W-1:0]        coef_wr_addr,
    input  logic [COEF_W-1:0]        coef_wr_data,
    input  logic                     coef_commit,
    output logic                     commit_pend,
    output logic                     fir_run,
    input  logic                     fir_busy,
    output logic [DATA_W-1:0]        fir_sample,
    input  logic [DATA_W-1:0]        fir_data,
    output logic [TAPS*COEF_W-1:0]   fir_coeff,
    output logic                     err_timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

    state_t            state_q, state_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [DATA_W-1:0] fir_sample_q, fir_sample_d;
    logic              fir_run_q, fir_run_d;
    logic              commit_pend_q, commit_pend_d;
    logic              err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  wait_cnt_inc;
    logic              accept;
    logic              copy_en;
    logic              out_free;

    // Handshakes, bank-copy decision and next-state logic for the sequencer.
    always_comb begin
        s_ready       = (state_q == IDLE) && !fir_busy;
        accept        = s_ready && s_valid;
        copy_en       = (state_q == IDLE) && !accept && (commit_pend_q || coef_commit);
        out_free      = !m_valid_q || m_ready;
        wait_cnt_inc  = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);

        state_d       = state_q;
        m_valid_d     = m_valid_q && !m_ready;
        m_data_d      = m_data_q;
        fir_sample_d  = fir_sample_q;
        fir_run_d     = 1'b0;
        err_timeout_d = err_timeout_q;
        wait_cnt_d    = wait_cnt_q;
        commit_pend_d = copy_en ? 1'b0 : (commit_pend_q || coef_commit);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    fir_sample_d = s_data;
                    fir_run_d    = 1'b1;
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (!fir_busy) begin
                    if (out_free) begin
                        m_data_d  = fir_data;
                        m_valid_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d   = HOLD;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                    if (wait_cnt_inc == CNT_TO) begin
                        err_timeout_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            HOLD: begin
                if (out_free) begin
                    m_data_d  = fir_data;
                    m_valid_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            fir_sample_q  <= '0;
            fir_run_q     <= 1'b0;
            commit_pend_q <= 1'b0;
            err_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            fir_sample_q  <= fir_sample_d;
            fir_run_q     <= fir_run_d;
            commit_pend_q <= commit_pend_d;
            err_timeout_q <= err_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    fir_coef_bank u_coef_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (coef_wr_en),
        .wr_addr    (coef_wr_addr),
        .wr_data    (coef_wr_data),
        .copy_en    (copy_en),
        .coeff_flat (fir_coeff)
    );

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign fir_sample  = fir_sample_q;
    assign fir_run     = fir_run_q;
    assign commit_pend = commit_pend_q;
    assign err_timeout = err_timeout_q;

endmodule
